// File: rtl/mux_sel_ctrl_pkg.sv
// Shared definitions for the mux select controller: state encodings,
// reset levels and counter-width helpers.
package mux_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    MAN_A  = 2'b00,
    MAN_B  = 2'b01,
    AUTO_A = 2'b10,
    AUTO_B = 2'b11
  } sel_state_e;

  localparam logic       KEY_RST_LVL    = 1'b1;
  localparam logic       AUTO_RST_LVL   = 1'b0;
  localparam logic [7:0] TOGGLE_CNT_RST = 8'd0;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // State encoding is {auto mode, select}, so the state is built from those two bits.
  function automatic sel_state_e make_state(input logic auto_m, input logic sel);
    return sel_state_e'({auto_m, sel});
  endfunction

endpackage

// File: rtl/mux_sel_ctrl_key_debounce.sv
// Push-button front end: two-flop synchroniser, level debounce counter and
// registered press (1->0) detector.
module key_debounce
  import mux_sel_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic [1:0]      sync_q, sync_d;
  logic [1:0]      vld_q, vld_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic            armed_q, armed_d;

  // Next-state for synchroniser, debounce counter and press detector.
  always_comb begin
    sync_d   = {sync_q[0], key_n};
    vld_d    = {vld_q[0], 1'b1};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + DB_ONE;
    end
    // A key held through reset must be seen released before a press can count.
    armed_d = armed_q | (vld_q[1] & sync_q[1]);
    press_d = armed_q & stable_q & ~stable_d;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= {2{KEY_RST_LVL}};
      vld_q    <= 2'b00;
      cnt_q    <= '0;
      stable_q <= KEY_RST_LVL;
      press_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      armed_q  <= armed_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/mux_sel_ctrl.sv
// Select-line controller for the 2:1 mux: toggles s on debounced key presses
// and, in auto mode, every AUTO_PERIOD cycles.
module mux_sel_ctrl
  import mux_sel_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_PERIOD     = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_n,
  input  logic       auto_en,
  output logic       s,
  output logic       sel_pulse,
  output logic [7:0] toggle_count,
  output logic [1:0] state_led
);

  localparam int               PER_W    = cnt_width(AUTO_PERIOD);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(AUTO_PERIOD - 1);
  localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);

  logic             key_stable_s, key_press_s;
  logic [1:0]       auto_sync_q, auto_sync_d;
  sel_state_e       state_q, state_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic             sel_pulse_q, sel_pulse_d;
  logic [7:0]       toggle_count_q, toggle_count_d;
  logic             in_auto_s, cur_sel_s, expire_s, toggle_s;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (CLOCK_50),
    .rst   (reset),
    .key_n (key_n),
    .stable(key_stable_s),
    .press (key_press_s)
  );

  // FSM next state, period counter and toggle bookkeeping.
  always_comb begin
    auto_sync_d = {auto_sync_q[0], auto_en};
    case (state_q)
      MAN_A:   begin in_auto_s = 1'b0; cur_sel_s = 1'b0; end
      MAN_B:   begin in_auto_s = 1'b0; cur_sel_s = 1'b1; end
      AUTO_A:  begin in_auto_s = 1'b1; cur_sel_s = 1'b0; end
      AUTO_B:  begin in_auto_s = 1'b1; cur_sel_s = 1'b1; end
      default: begin in_auto_s = 1'b0; cur_sel_s = 1'b0; end
    endcase
    expire_s = in_auto_s & auto_sync_q[1] & (per_cnt_q == PER_LAST);
    // A press with expiry in the same cycle is still a single toggle.
    toggle_s = (key_press_s & ~key_stable_s) | expire_s;
    state_d  = make_state(auto_sync_q[1], cur_sel_s ^ toggle_s);
    if (auto_sync_q[1] && in_auto_s && !toggle_s) begin
      per_cnt_d = per_cnt_q + PER_ONE;
    end else begin
      per_cnt_d = '0;
    end
    sel_pulse_d    = toggle_s;
    toggle_count_d = toggle_count_q + {7'd0, toggle_s};
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      auto_sync_q    <= {2{AUTO_RST_LVL}};
      state_q        <= MAN_A;
      per_cnt_q      <= '0;
      sel_pulse_q    <= 1'b0;
      toggle_count_q <= TOGGLE_CNT_RST;
    end else begin
      auto_sync_q    <= auto_sync_d;
      state_q        <= state_d;
      per_cnt_q      <= per_cnt_d;
      sel_pulse_q    <= sel_pulse_d;
      toggle_count_q <= toggle_count_d;
    end
  end

  assign state_led    = state_q;
  assign s            = state_q[0];
  assign sel_pulse    = sel_pulse_q;
  assign toggle_count = toggle_count_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Scoreboard bench for mux_sel_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
module tb_mux_sel_ctrl;

  localparam int DB = 4;
  localparam int AP = 8;

  logic       clk = 1'b0;
  logic       rst, key_n, auto_en;
  logic       s, sel_pulse;
  logic [7:0] toggle_count;
  logic [1:0] state_led;

  typedef struct {
    logic       s;
    logic [7:0] cnt;
    logic [1:0] st;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mux_sel_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_PERIOD    (AP)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .key_n       (key_n),
    .auto_en     (auto_en),
    .s           (s),
    .sel_pulse   (sel_pulse),
    .toggle_count(toggle_count),
    .state_led   (state_led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sv, input logic [7:0] cnt, input logic [1:0] st, input int at);
    exp_t e;
    e.s = sv; e.cnt = cnt; e.st = st; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s"}, s, 0);
    check({tag, "_pulse"}, sel_pulse, 0);
    check({tag, "_count"}, toggle_count, 0);
    check({tag, "_state"}, state_led, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Monitor: every select strobe must match the next expected toggle.
  always @(negedge clk) begin
    if (rst === 1'b0 && sel_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got strobe at edge %0d, want none (s=%0b count=%0d)",
                 cyc, s, toggle_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_edge", cyc, e.at);
        check("pulse_s", s, e.s);
        check("pulse_count", toggle_count, e.cnt);
        check("pulse_state", state_led, e.st);
      end
    end
  end

  initial begin
    int e;
    rst = 1'b1; key_n = 1'b1; auto_en = 1'b0;
    step(3);
    rst = 1'b0;
    check_reset_vals("reset");
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_reset_vals("idle");
    end

    // Two debounced presses, each landing 7 edges after key_n falls.
    e = cyc; key_n = 1'b0;
    push(1'b1, 8'd1, 2'b01, e + 7);
    step(20);
    check("press1_count", toggle_count, 1);
    check("press1_state", state_led, 2'b01);
    key_n = 1'b1; step(12);
    e = cyc; key_n = 1'b0;
    push(1'b0, 8'd2, 2'b00, e + 7);
    step(20);
    key_n = 1'b1; step(12);
    check("press2_count", toggle_count, 2);

    // Glitches shorter than the debounce window.
    for (int w = 1; w <= 3; w++) begin
      key_n = 1'b0; step(w);
      key_n = 1'b1; step(10);
    end
    check("glitch_s", s, 0);
    check("glitch_count", toggle_count, 2);

    // Auto mode: entry 3 edges after auto_en, then a toggle every 8 edges.
    do_reset; step(5);
    e = cyc; auto_en = 1'b1;
    for (int k = 1; k <= 4; k++) push(k[0], k[7:0], {1'b1, k[0]}, e + 3 + 8 * k);
    step(4);
    check("auto_entry_state", state_led, 2'b10);
    step(31);
    check("auto_count", toggle_count, 4);
    auto_en = 1'b0;
    step(5);
    check("auto_exit_state", state_led, 2'b00);
    step(20);
    check("auto_exit_s", s, 0);
    check("auto_exit_count", toggle_count, 4);

    // Press event lands on the first expiry, then 258 toggles total to wrap.
    do_reset; step(5);
    e = cyc; auto_en = 1'b1;
    for (int k = 1; k <= 258; k++) push(k[0], k[7:0], {1'b1, k[0]}, e + 11 + 8 * (k - 1));
    step(4);
    key_n = 1'b0;
    step(8);
    key_n = 1'b1;
    step(1000);
    check("wrap_mid_state_auto", state_led[1], 1);
    step(1060);
    check("wrap_count", toggle_count, 2);
    auto_en = 1'b0;
    step(5);

    // Reset two edges into a debounce, with the key held through reset.
    do_reset; step(5);
    e = cyc; key_n = 1'b0;
    push(1'b1, 8'd1, 2'b01, e + 7);
    step(20);
    key_n = 1'b1; step(12);
    check("pre_reset_count", toggle_count, 1);
    key_n = 1'b0; step(2);
    rst = 1'b1; #1;
    check_reset_vals("rst_debounce");
    step(3);
    rst = 1'b0;
    step(30);
    check("held_key_s", s, 0);
    check("held_key_count", toggle_count, 0);
    key_n = 1'b1; step(12);
    e = cyc; key_n = 1'b0;
    push(1'b1, 8'd1, 2'b01, e + 7);
    step(20);
    key_n = 1'b1; step(12);

    // Reset in the middle of an auto period.
    e = cyc; auto_en = 1'b1;
    push(1'b0, 8'd2, 2'b10, e + 11);
    step(14);
    check("mid_period_count", toggle_count, 2);
    rst = 1'b1; #1;
    check_reset_vals("rst_period");
    auto_en = 1'b0;
    step(3);
    rst = 1'b0;
    step(10);
    check_reset_vals("after_rst");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
